// File: rtl/fdam_rd_req_pkg.sv
// Shared state encoding and credit-window helper for the FDAM read-request generator.
package fdam_rd_req_pkg;

  localparam int unsigned DEF_DATA_WIDTH           = 32;
  localparam int unsigned DEF_MAX_OUTSTANDING_BITS = 4;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_DRAIN = 2'd2,
    ST_DONE  = 2'd3
  } rd_req_state_e;

  // Number of requests allowed in flight for a given counter width.
  function automatic int unsigned credit_limit(input int unsigned bits);
    return 32'd1 << bits;
  endfunction

endpackage

// File: rtl/fdam_rd_req_credit_counter.sv
// Outstanding-request counter: tracks issued-but-unreturned lines and flags
// returns that arrive when nothing is outstanding.
module fdam_rd_req_credit_counter
  import fdam_rd_req_pkg::*;
#(
  parameter int unsigned CNT_BITS = DEF_MAX_OUTSTANDING_BITS
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic inc_i,
  input  logic dec_i,
  output logic credit_avail_o,
  output logic underflow_o
);

  localparam logic [CNT_BITS:0] LIMIT = (CNT_BITS + 1)'(credit_limit(CNT_BITS));

  logic [CNT_BITS:0] count_q, count_d;
  logic              dec_ok;

  assign underflow_o    = dec_i && (count_q == '0);
  assign dec_ok         = dec_i && !underflow_o;
  assign credit_avail_o = (count_q < LIMIT);

  // A simultaneous issue and accepted return cancel out.
  always_comb begin
    count_d = count_q;
    if (clr_i) begin
      count_d = '0;
    end else if (inc_i && !dec_ok) begin
      count_d = count_q + 1'b1;
    end else if (dec_ok && !inc_i) begin
      count_d = count_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/fdam_rd_req_generator.sv
// Per-channel read-request source: issues one cache-line address per cycle into the
// arbiter, limited by arbiter backpressure and a credit window, and pulses done on completion.
module fdam_rd_req_generator
  import fdam_rd_req_pkg::*;
#(
  parameter int unsigned DATA_WIDTH           = DEF_DATA_WIDTH,
  parameter int unsigned MAX_OUTSTANDING_BITS = DEF_MAX_OUTSTANDING_BITS
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [DATA_WIDTH-1:0] cfg_base_addr,
  input  logic [DATA_WIDTH-1:0] cfg_num_lines,
  input  logic                  rd_data_valid,
  input  logic                  req_wr_available,
  output logic                  req_wr_en,
  output logic [DATA_WIDTH-1:0] req_wr_data,
  output logic                  busy,
  output logic                  done,
  output logic                  err
);

  rd_req_state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] remaining_q, remaining_d;
  logic [DATA_WIDTH-1:0] pending_q, pending_d;

  logic                  req_wr_en_q, req_wr_en_d;
  logic [DATA_WIDTH-1:0] req_wr_data_q, req_wr_data_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  err_q, err_d;

  logic start_ok;
  logic issue;
  logic ret_ok;
  logic credit_avail;
  logic underflow;

  assign start_ok = start && (state_q == ST_IDLE);
  assign issue    = (state_q == ST_ISSUE) && (remaining_q != '0) &&
                    req_wr_available && credit_avail;
  // Outstanding is zero outside ISSUE/DRAIN, so idle returns always land as underflow.
  assign ret_ok   = rd_data_valid && !underflow;

  fdam_rd_req_credit_counter #(
    .CNT_BITS (MAX_OUTSTANDING_BITS)
  ) u_credit (
    .clk            (clk),
    .rst_n          (rst),
    .clr_i          (start_ok),
    .inc_i          (issue),
    .dec_i          (rd_data_valid),
    .credit_avail_o (credit_avail),
    .underflow_o    (underflow)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = (cfg_num_lines == '0) ? ST_DONE : ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (issue && (remaining_q == DATA_WIDTH'(1))) begin
          state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (ret_ok && (pending_q == DATA_WIDTH'(1))) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    req_wr_en_d   = issue;
    req_wr_data_d = issue ? addr_q : req_wr_data_q;
    busy_d        = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
    done_d        = (state_q == ST_DONE);
    err_d         = start_ok ? 1'b0 : (err_q | underflow);
  end

  always_comb begin
    addr_d      = addr_q;
    remaining_d = remaining_q;
    pending_d   = pending_q;
    if (start_ok) begin
      addr_d      = cfg_base_addr;
      remaining_d = cfg_num_lines;
      pending_d   = cfg_num_lines;
    end
    if (issue) begin
      addr_d      = addr_q + 1'b1;
      remaining_d = remaining_q - 1'b1;
    end
    if (ret_ok) begin
      pending_d = pending_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      addr_q        <= '0;
      remaining_q   <= '0;
      pending_q     <= '0;
      req_wr_en_q   <= 1'b0;
      req_wr_data_q <= '0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
      err_q         <= 1'b0;
    end else begin
      addr_q        <= addr_d;
      remaining_q   <= remaining_d;
      pending_q     <= pending_d;
      req_wr_en_q   <= req_wr_en_d;
      req_wr_data_q <= req_wr_data_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
      err_q         <= err_d;
    end
  end

  assign req_wr_en   = req_wr_en_q;
  assign req_wr_data = req_wr_data_q;
  assign busy        = busy_q;
  assign done        = done_q;
  assign err         = err_q;

endmodule

// File: tb/tb_fdam_rd_req_generator.sv
// Self-checking bench for fdam_rd_req_generator: scenario tasks plus randomized jobs
// checked against an arithmetic model of the issue rules.
module tb_fdam_rd_req_generator;

  localparam int DW    = 32;
  localparam int MAXC  = 20000;
  localparam int LIMIT = 16;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start = 1'b0;
  logic [DW-1:0] cfg_base_addr = '0;
  logic [DW-1:0] cfg_num_lines = '0;
  logic          rd_data_valid = 1'b0;
  logic          req_wr_available = 1'b0;
  logic          req_wr_en;
  logic [DW-1:0] req_wr_data;
  logic          busy;
  logic          done;
  logic          err;

  int n_cmp = 0;
  int n_bad = 0;
  int cyc   = 0;

  bit wr_at    [MAXC];
  bit ret_at   [MAXC];
  bit avail_at [MAXC];
  bit busy_at  [MAXC];

  logic [DW-1:0] wr_q[$];
  int            wr_cyc_q[$];
  int            ret_sched[$];
  int            done_cnt;
  int            done_cyc;
  int            avail_mode;
  bit            auto_ret;
  int            ret_dly;

  always #5 clk = ~clk;

  fdam_rd_req_generator #(
    .DATA_WIDTH           (DW),
    .MAX_OUTSTANDING_BITS (4)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .start            (start),
    .cfg_base_addr    (cfg_base_addr),
    .cfg_num_lines    (cfg_num_lines),
    .rd_data_valid    (rd_data_valid),
    .req_wr_available (req_wr_available),
    .req_wr_en        (req_wr_en),
    .req_wr_data      (req_wr_data),
    .busy             (busy),
    .done             (done),
    .err              (err)
  );

  // One clock: observe registered outputs just after the edge, then drive next inputs.
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (cyc < MAXC) begin
      busy_at[cyc] = busy;
      if (req_wr_en === 1'b1) begin
        wr_q.push_back(req_wr_data);
        wr_cyc_q.push_back(cyc);
        wr_at[cyc] = 1'b1;
        if (auto_ret) ret_sched.push_back(cyc + ret_dly);
      end
      if (done === 1'b1) begin
        done_cnt++;
        done_cyc = cyc;
      end
      rd_data_valid = 1'b0;
      if (ret_sched.size() > 0 && ret_sched[0] <= cyc) begin
        rd_data_valid = 1'b1;
        void'(ret_sched.pop_front());
        ret_at[cyc] = 1'b1;
      end
      case (avail_mode)
        0:       req_wr_available = 1'b1;
        1:       req_wr_available = cyc[0];
        default: req_wr_available = ($urandom_range(0, 3) != 0);
      endcase
      avail_at[cyc] = req_wr_available;
    end
  endtask

  task automatic clear_logs();
    wr_q.delete();
    wr_cyc_q.delete();
    ret_sched.delete();
    done_cnt = 0;
    done_cyc = 0;
  endtask

  task automatic start_job(input logic [DW-1:0] b, input logic [DW-1:0] n, output int s);
    cfg_base_addr = b;
    cfg_num_lines = n;
    start = 1'b1;
    s = cyc;
    step();
    start = 1'b0;
    cfg_base_addr = $urandom;
    cfg_num_lines = $urandom;
    $display("job base=%h lines=%0d start_cyc=%0d", b, n, s);
  endtask

  task automatic wait_done(input int budget, output bit ok);
    int k;
    int d0;
    k  = 0;
    d0 = done_cnt;
    while (done_cnt == d0 && k < budget) begin
      step();
      k++;
    end
    ok = (done_cnt != d0);
  endtask

  task automatic test_reset();
    rst = 1'b0;
    avail_mode = 2;
    for (int i = 0; i < 6; i++) begin
      start = 1'($urandom);
      cfg_base_addr = $urandom;
      cfg_num_lines = $urandom;
      step();
      rd_data_valid = 1'($urandom);
      n_cmp++;
      if ({req_wr_en, req_wr_data, busy, done, err} !== '0) begin
        n_bad++;
        $display("FAIL reset_outputs cyc=%0d got en=%b data=%h busy=%b done=%b err=%b, required all 0",
                 cyc, req_wr_en, req_wr_data, busy, done, err);
      end
    end
    start = 1'b0;
    rd_data_valid = 1'b0;
    rst = 1'b1;
    avail_mode = 0;
    step();
    step();
    n_cmp++;
    if ({req_wr_en, busy, done, err} !== 4'b0) begin
      n_bad++;
      $display("FAIL reset_release got en=%b busy=%b done=%b err=%b, required 0", req_wr_en, busy, done, err);
    end
  endtask

  task automatic test_basic();
    int s;
    bit ok;
    int bad;
    logic [DW-1:0] base;
    base = 32'h100;
    clear_logs();
    avail_mode = 0;
    auto_ret = 1'b1;
    ret_dly = 3;
    start_job(base, 4, s);
    wait_done(200, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL basic_timeout no done within budget"); end
    n_cmp++;
    if (wr_q.size() != 4) begin n_bad++; $display("FAIL basic_count got %0d writes, required 4", wr_q.size()); end
    for (int i = 0; i < wr_q.size() && i < 4; i++) begin
      n_cmp++;
      if (wr_q[i] !== base + 32'(i)) begin
        n_bad++; $display("FAIL basic_addr[%0d] got %h, required %h", i, wr_q[i], base + 32'(i));
      end
      n_cmp++;
      if (wr_cyc_q[i] != s + 2 + i) begin
        n_bad++; $display("FAIL basic_timing[%0d] got cyc %0d, required %0d", i, wr_cyc_q[i], s + 2 + i);
      end
    end
    if (ok && wr_cyc_q.size() == 4) begin
      n_cmp++;
      if (done_cyc != wr_cyc_q[3] + 3 + 2) begin
        n_bad++; $display("FAIL basic_done_time got %0d, required %0d", done_cyc, wr_cyc_q[3] + 5);
      end
      bad = 0;
      for (int c = s + 2; c < done_cyc; c++) if (!busy_at[c]) bad++;
      n_cmp++;
      if (bad != 0) begin n_bad++; $display("FAIL basic_busy low in %0d job cycles, required 0", bad); end
      n_cmp++;
      if (busy_at[done_cyc] !== 1'b0) begin n_bad++; $display("FAIL basic_busy_at_done got 1, required 0"); end
    end
    repeat (5) step();
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL basic_done_pulses got %0d, required 1", done_cnt); end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL basic_err got %b, required 0", err); end
  endtask

  task automatic test_backpressure();
    int s;
    bit ok;
    int bad;
    int badaddr;
    logic [DW-1:0] base;
    base = $urandom;
    clear_logs();
    avail_mode = 1;
    auto_ret = 1'b1;
    ret_dly = $urandom_range(1, 6);
    start_job(base, 8, s);
    wait_done(300, ok);
    repeat (4) step();
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL bp_timeout no done within budget"); end
    n_cmp++;
    if (wr_q.size() != 8) begin n_bad++; $display("FAIL bp_count got %0d writes, required 8", wr_q.size()); end
    bad = 0;
    badaddr = 0;
    for (int i = 0; i < wr_q.size(); i++) begin
      if (wr_q[i] !== base + 32'(i)) badaddr++;
      if (!avail_at[wr_cyc_q[i] - 1]) bad++;
    end
    n_cmp++;
    if (badaddr != 0) begin n_bad++; $display("FAIL bp_order %0d out-of-order addresses, required 0", badaddr); end
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL bp_late_write %0d writes without prior available, required 0", bad); end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL bp_done_pulses got %0d, required 1", done_cnt); end
  endtask

  task automatic test_credit_limit();
    int s;
    int c0;
    bit ok;
    logic [DW-1:0] base;
    base = $urandom;
    clear_logs();
    avail_mode = 0;
    auto_ret = 1'b0;
    start_job(base, 20, s);
    repeat (25) step();
    n_cmp++;
    if (wr_q.size() != LIMIT) begin n_bad++; $display("FAIL credit_stall got %0d writes, required %0d", wr_q.size(), LIMIT); end
    n_cmp++;
    if (done_cnt != 0) begin n_bad++; $display("FAIL credit_early_done got %0d, required 0", done_cnt); end
    ret_sched.push_back(cyc + 1);
    repeat (6) step();
    n_cmp++;
    if (wr_q.size() != 17) begin n_bad++; $display("FAIL credit_ret1 got %0d writes, required 17", wr_q.size()); end
    else begin
      n_cmp++;
      if (wr_q[16] !== base + 32'd16) begin n_bad++; $display("FAIL credit_addr16 got %h, required %h", wr_q[16], base + 32'd16); end
    end
    repeat (4) step();
    ret_sched.push_back(cyc + 1);
    repeat (6) step();
    n_cmp++;
    if (wr_q.size() != 18) begin n_bad++; $display("FAIL credit_ret2 got %0d writes, required 18", wr_q.size()); end
    repeat (10) step();
    n_cmp++;
    if (wr_q.size() != 18) begin n_bad++; $display("FAIL credit_restall got %0d writes, required 18", wr_q.size()); end
    c0 = cyc;
    for (int i = 1; i <= 18; i++) ret_sched.push_back(c0 + i);
    repeat (17) step();
    n_cmp++;
    if (wr_q.size() != 20) begin n_bad++; $display("FAIL credit_total got %0d writes, required 20", wr_q.size()); end
    n_cmp++;
    if (done_cnt != 0) begin n_bad++; $display("FAIL credit_done_before_last got %0d, required 0", done_cnt); end
    wait_done(20, ok);
    n_cmp++;
    if (!ok) begin n_bad++; $display("FAIL credit_timeout no done within budget"); end
    else begin
      n_cmp++;
      if (done_cyc != c0 + 18 + 2) begin n_bad++; $display("FAIL credit_done_time got %0d, required %0d", done_cyc, c0 + 20); end
    end
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL credit_err got %b, required 0", err); end
  endtask

  task automatic test_zero_and_wrap();
    int s;
    bit ok;
    int bad;
    logic [DW-1:0] base;
    clear_logs();
    avail_mode = 0;
    auto_ret = 1'b1;
    ret_dly = 2;
    start_job($urandom, 0, s);
    repeat (5) step();
    n_cmp++;
    if (wr_q.size() != 0) begin n_bad++; $display("FAIL zero_writes got %0d, required 0", wr_q.size()); end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL zero_done_pulses got %0d, required 1", done_cnt); end
    n_cmp++;
    if (done_cyc != s + 2) begin n_bad++; $display("FAIL zero_done_time got %0d, required %0d", done_cyc, s + 2); end
    bad = 0;
    for (int c = s + 1; c <= cyc; c++) if (busy_at[c]) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL zero_busy high %0d cycles, required 0", bad); end

    clear_logs();
    base = 32'hFFFF_FFFE;
    start_job(base, 3, s);
    wait_done(100, ok);
    n_cmp++;
    if (!ok || wr_q.size() != 3) begin
      n_bad++; $display("FAIL wrap_count got %0d writes done=%0b, required 3 and done", wr_q.size(), ok);
    end
    for (int i = 0; i < wr_q.size() && i < 3; i++) begin
      n_cmp++;
      if (wr_q[i] !== base + 32'(i)) begin
        n_bad++; $display("FAIL wrap_addr[%0d] got %h, required %h", i, wr_q[i], base + 32'(i));
      end
    end
  endtask

  task automatic test_err_and_start();
    int s;
    bit ok;
    int bad;
    logic [DW-1:0] base;
    clear_logs();
    avail_mode = 0;
    auto_ret = 1'b1;
    ret_dly = 4;
    ret_sched.push_back(cyc + 1);
    repeat (3) step();
    n_cmp++;
    if (err !== 1'b1) begin n_bad++; $display("FAIL err_idle_return got %b, required 1", err); end
    start_job($urandom, 1, s);
    n_cmp++;
    if (err !== 1'b0) begin n_bad++; $display("FAIL err_clear_on_start got %b, required 0", err); end
    wait_done(50, ok);
    n_cmp++;
    if (!ok || err !== 1'b0) begin n_bad++; $display("FAIL err_job got done=%0b err=%b, required 1 and 0", ok, err); end

    clear_logs();
    base = $urandom;
    start_job(base, 6, s);
    step();
    step();
    cfg_base_addr = $urandom;
    cfg_num_lines = 50;
    start = 1'b1;
    step();
    start = 1'b0;
    wait_done(200, ok);
    repeat (10) step();
    n_cmp++;
    if (wr_q.size() != 6) begin n_bad++; $display("FAIL ign_start_count got %0d writes, required 6", wr_q.size()); end
    bad = 0;
    for (int i = 0; i < wr_q.size(); i++) if (wr_q[i] !== base + 32'(i)) bad++;
    n_cmp++;
    if (bad != 0) begin n_bad++; $display("FAIL ign_start_addr %0d wrong addresses, required 0", bad); end
    n_cmp++;
    if (done_cnt != 1) begin n_bad++; $display("FAIL ign_start_done got %0d, required 1", done_cnt); end
  endtask

  task automatic test_mid_reset();
    int s;
    int k;
    bit ok;
    logic [DW-1:0] base;
    clear_logs();
    avail_mode = 0;
    auto_ret = 1'b0;
    start_job($urandom, 10, s);
    k = 0;
    while (wr_q.size() < 5 && k < 50) begin
      step();
      k++;
    end
    n_cmp++;
    if (wr_q.size() != 5) begin n_bad++; $display("FAIL midrst_setup got %0d writes, required 5", wr_q.size()); end
    rst = 1'b0;
    #1;
    n_cmp++;
    if ({req_wr_en, req_wr_data, busy, done, err} !== '0) begin
      n_bad++;
      $display("FAIL midrst_async got en=%b data=%h busy=%b done=%b err=%b, required all 0",
               req_wr_en, req_wr_data, busy, done, err);
    end
    step();
    rst = 1'b1;
    repeat (10) step();
    n_cmp++;
    if (wr_q.size() != 5) begin n_bad++; $display("FAIL midrst_no_writes got %0d writes, required 5", wr_q.size()); end
    n_cmp++;
    if (busy !== 1'b0 || done_cnt != 0) begin
      n_bad++; $display("FAIL midrst_idle got busy=%b done_cnt=%0d, required 0 and 0", busy, done_cnt);
    end
    clear_logs();
    auto_ret = 1'b1;
    ret_dly = 3;
    base = $urandom;
    start_job(base, 2, s);
    wait_done(50, ok);
    n_cmp++;
    if (!ok || wr_q.size() != 2) begin
      n_bad++; $display("FAIL midrst_restart got %0d writes done=%0b, required 2 and done", wr_q.size(), ok);
    end else begin
      n_cmp++;
      if (wr_q[0] !== base || wr_cyc_q[0] != s + 2) begin
        n_bad++; $display("FAIL midrst_restart_first got %h@%0d, required %h@%0d", wr_q[0], wr_cyc_q[0], base, s + 2);
      end
    end
  endtask

  // Randomized jobs: every cycle of the job, a write must appear exactly when the
  // previous cycle had available=1, fewer than LIMIT lines in flight and lines left.
  task automatic test_random();
    int s;
    int n;
    int w;
    int r;
    int bad;
    int badaddr;
    int last;
    bit ok;
    bit exp_wr;
    logic [DW-1:0] base;
    for (int j = 0; j < 5; j++) begin
      clear_logs();
      base = $urandom;
      n = $urandom_range(1, 40);
      avail_mode = 2;
      auto_ret = 1'b1;
      ret_dly = $urandom_range(1, 30);
      start_job(base, n, s);
      wait_done(3000, ok);
      n_cmp++;
      if (!ok) begin n_bad++; $display("FAIL rnd%0d_timeout no done within budget", j); end
      n_cmp++;
      if (wr_q.size() != n) begin n_bad++; $display("FAIL rnd%0d_count got %0d, required %0d", j, wr_q.size(), n); end
      if (ok && wr_q.size() == n) begin
        badaddr = 0;
        for (int i = 0; i < n; i++) if (wr_q[i] !== base + 32'(i)) badaddr++;
        n_cmp++;
        if (badaddr != 0) begin n_bad++; $display("FAIL rnd%0d_addr %0d wrong addresses, required 0", j, badaddr); end
        last = wr_cyc_q[n - 1];
        w = 0;
        r = 0;
        bad = 0;
        for (int c = s + 1; c < last; c++) begin
          exp_wr = avail_at[c] && ((w - r) < LIMIT) && (w < n);
          if (exp_wr != wr_at[c + 1]) begin
            if (bad == 0) $display("FAIL rnd%0d_issue first at cyc %0d got write=%0b, required %0b", j, c + 1, wr_at[c + 1], exp_wr);
            bad++;
          end
          w += int'(wr_at[c + 1]);
          r += int'(ret_at[c]);
        end
        n_cmp++;
        if (bad != 0) begin n_bad++; $display("FAIL rnd%0d_issue_rule %0d cycles differ, required 0", j, bad); end
        n_cmp++;
        if (done_cyc != last + ret_dly + 2) begin
          n_bad++; $display("FAIL rnd%0d_done_time got %0d, required %0d", j, done_cyc, last + ret_dly + 2);
        end
      end
      n_cmp++;
      if (err !== 1'b0) begin n_bad++; $display("FAIL rnd%0d_err got %b, required 0", j, err); end
    end
  endtask

  initial begin
    avail_mode = 0;
    auto_ret   = 1'b0;
    ret_dly    = 3;
    clear_logs();
    test_reset();
    test_basic();
    test_backpressure();
    test_credit_limit();
    test_zero_and_wrap();
    test_err_and_start();
    test_mid_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/fdam_rd_req_generator.md
Name: fdam_rd_req_generator

Overview:
- Per-channel read-request source that feeds the single-input read-request arbiter tree (its req_wr_en_in/req_wr_data_in port).
- Once started with a base cache-line address and a line count, it emits one request word per line into the arbiter.
- Issue rate is limited by arbiter backpressure and by an outstanding-request credit window.
- Signals done once every requested line has returned.

Parameters:
- DATA_WIDTH, 32, request word width; the word carries the cache-line address.
- MAX_OUTSTANDING_BITS, 4, credit window is 2**MAX_OUTSTANDING_BITS outstanding requests (16).

Ports:
- clk  input  1  clock
- rst  input  1  asynchronous, active-low reset (0 = reset)
- start  input  1  one-cycle pulse; honoured only in IDLE
- cfg_base_addr  input  DATA_WIDTH  first cache-line address; sampled on an accepted start
- cfg_num_lines  input  DATA_WIDTH  number of lines; sampled on an accepted start
- rd_data_valid  input  1  one pulse per returned line (credit return)
- req_wr_available  input  1  arbiter input FIFO can absorb a write next cycle
- req_wr_en  output  1  request write strobe to the arbiter
- req_wr_data  output  DATA_WIDTH  request address
- busy  output  1  high in ISSUE or DRAIN
- done  output  1  one-cycle pulse at job completion
- err  output  1  sticky: a return arrived with zero requests outstanding

Behaviour:
- Reset (rst=0, asynchronous) clears all outputs: req_wr_en=0, req_wr_data=0, busy=0, done=0, err=0.
- Reset also clears all counters and forces state to IDLE, including mid-job. In-flight returns after reset are not tracked.
- All outputs are registered.
- Internal state:
  - addr: DATA_WIDTH bits
  - remaining: DATA_WIDTH bits
  - outstanding: MAX_OUTSTANDING_BITS+1 bits
  - pending_ret: DATA_WIDTH bits, counts lines not yet returned
- IDLE:
  - On start, latch addr=cfg_base_addr, remaining=cfg_num_lines, pending_ret=cfg_num_lines, and clear err.
  - If cfg_num_lines=0, go to DONE; otherwise go to ISSUE.
- Issue condition, evaluated in cycle t: state=ISSUE, remaining!=0, req_wr_available=1, and outstanding < 2**MAX_OUTSTANDING_BITS.
  - In cycle t+1: req_wr_en=1 and req_wr_data=addr.
  - In the same update: addr increments by 1 modulo 2**DATA_WIDTH (wraps silently), remaining decrements, outstanding increments.
  - If the condition fails, req_wr_en=0 in t+1.
- req_wr_available is treated as almost-full derived, so one write in flight after it drops is tolerated.
- Issue is capped at one request per cycle; a back-to-back maximum rate is required when unthrottled.
- ISSUE -> DRAIN when the final issue occurs (remaining goes 1 -> 0).
- Credit return: rd_data_valid with outstanding>0 decrements outstanding and pending_ret.
  - An issue and a return in the same cycle leave outstanding unchanged.
  - rd_data_valid with outstanding=0 is ignored, except that it sets err=1.
  - Returns are accepted in ISSUE and DRAIN; in IDLE or DONE they only set err.
- DRAIN -> DONE when pending_ret reaches 0. The last return is counted before leaving.
- DONE: done=1 for exactly one cycle, then IDLE. busy=0 in DONE.
- start outside IDLE is ignored; config is not re-sampled.
- Latency: first req_wr_en appears 2 cycles after start (one cycle to enter ISSUE, one for the registered output), given available=1.

Decomposition:
- Package fdam_rd_req_pkg: FSM state encoding (IDLE, ISSUE, DRAIN, DONE, 2 bits) and the credit-limit constant derived from MAX_OUTSTANDING_BITS.
- Sub-module fdam_rd_req_credit_counter: the outstanding counter.
  - Inputs: inc, dec, clr.
  - Outputs: credit_avail and underflow; underflow drives err.

Test Plan:
- Reset and basic job:
  - Stimulus: hold rst=0 with random inputs, release, then start with base=0x100, lines=4, available=1, returning each line 3 cycles after issue.
  - Required: all outputs 0 during reset; writes of 0x100..0x103 on consecutive cycles starting 2 cycles after start; busy high until done; exactly one done pulse.
- Backpressure:
  - Stimulus: lines=8, available toggled 1/0 every cycle.
  - Required: exactly 8 writes, in address order, and no write more than one cycle after available drops.
- Credit limit:
  - Stimulus: lines=20 with no returns.
  - Required: exactly 16 writes, then stall. Then a single return, with another single return 10 cycles later.
  - Required: one further write after each return; done only after all 20 lines have returned.
- Zero length and wrap:
  - Stimulus: lines=0.
  - Required: done 2 cycles after start with no writes.
  - Stimulus: base=0xFFFFFFFE, lines=3.
  - Required: writes 0xFFFFFFFE, 0xFFFFFFFF, 0x00000000.
- Error, ignored start and mid-job reset:
  - Stimulus: rd_data_valid in IDLE.
  - Required: err=1, cleared by the next start.
  - Stimulus: start pulsed during ISSUE.
  - Required: ignored.
  - Stimulus: rst=0 after 5 issues of a 10-line job.
  - Required: outputs 0 immediately; IDLE after release; no further writes.
